alu_8bit: RTL and testbench



---
 rtl/alu_pkg.sv | 36 +++
 rtl/alu_comb.sv | 69 ++++++
 rtl/alu_8bit.sv | 43 ++++
 tb/tb_alu_8bit.sv | 179 +++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// alu_pkg: shared opcode encoding, flag bit positions and data width for the
// 8-bit ALU.
package alu_pkg;

  localparam int DATA_W = 8;
  localparam int FUN_W  = 3;
  localparam int FLAG_W = 3;

  // Bit positions inside the status vector
  localparam int FLAG_Z = 0;
  localparam int FLAG_C = 1;
  localparam int FLAG_N = 2;

  typedef enum logic [FUN_W-1:0] {
    ADD = 3'b000,
    SUB = 3'b001,
    AND = 3'b010,
    OR  = 3'b011,
    XOR = 3'b100,
    NOT = 3'b101,
    SHL = 3'b110,  // ROL when ALU_ROTATE_EN is defined
    SHR = 3'b111   // ROR when ALU_ROTATE_EN is defined
  } alu_op_e;

  // Zero and negative are derived from the result alone, for every opcode
  function automatic logic [FLAG_W-1:0] make_flags(input logic [DATA_W-1:0] res,
                                                   input logic carry);
    logic [FLAG_W-1:0] f;
    f         = '0;
    f[FLAG_Z] = (res == '0);
    f[FLAG_C] = carry;
    f[FLAG_N] = res[DATA_W-1];
    return f;
  endfunction

endpackage

// File: rtl/alu_comb.sv
// alu_comb: purely combinational ALU datapath producing next result and flags.
// Build option: ALU_ROTATE_EN turns opcodes 110/111 into rotates instead of
// logical shifts.
module alu_comb
  import alu_pkg::*;
(
  input  logic [FUN_W-1:0]  fun,
  input  logic [DATA_W-1:0] Rx,
  input  logic [DATA_W-1:0] Ry,
  output logic [DATA_W-1:0] next_result,
  output logic [FLAG_W-1:0] next_band
);

  logic [DATA_W:0]   w_sum;
  logic [DATA_W:0]   w_diff;
  logic [DATA_W-1:0] w_res;
  logic              w_carry;

  // 9-bit add/subtract; bit 8 of the difference is the unsigned borrow
  assign w_sum  = {1'b0, Rx} + {1'b0, Ry};
  assign w_diff = {1'b0, Rx} - {1'b0, Ry};

  // Opcode decode: select result and carry/borrow
  always_comb begin
    w_res   = '0;
    w_carry = 1'b0;
    case (alu_op_e'(fun))
      ADD: begin
        w_res   = w_sum[DATA_W-1:0];
        w_carry = w_sum[DATA_W];
      end
      SUB: begin
        w_res   = w_diff[DATA_W-1:0];
        w_carry = w_diff[DATA_W];
      end
      AND: w_res = Rx & Ry;
      OR:  w_res = Rx | Ry;
      XOR: w_res = Rx ^ Ry;
      NOT: w_res = ~Rx;
`ifdef ALU_ROTATE_EN
      SHL: begin
        w_res   = {Rx[DATA_W-2:0], Rx[DATA_W-1]};
        w_carry = Rx[DATA_W-1];
      end
      SHR: begin
        w_res   = {Rx[0], Rx[DATA_W-1:1]};
        w_carry = Rx[0];
      end
`else
      SHL: begin
        w_res   = {Rx[DATA_W-2:0], 1'b0};
        w_carry = Rx[DATA_W-1];
      end
      SHR: begin
        w_res   = {1'b0, Rx[DATA_W-1:1]};
        w_carry = Rx[0];
      end
`endif
      default: begin
        w_res   = '0;
        w_carry = 1'b0;
      end
    endcase
  end

  assign next_result = w_res;
  assign next_band   = make_flags(w_res, w_carry);

endmodule

// File: rtl/alu_8bit.sv
// alu_8bit: 8-bit ALU with registered Result and flags (Z, C, N), one-cycle
// latency, one operation per clock, asynchronous active-low reset.
// Build option: ALU_ROTATE_EN (see alu_comb) selects rotates for 110/111.
module alu_8bit
  import alu_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic [FUN_W-1:0]  fun,
  input  logic [DATA_W-1:0] Rx,
  input  logic [DATA_W-1:0] Ry,
  output logic [DATA_W-1:0] Result,
  output logic [FLAG_W-1:0] band
);

  logic [DATA_W-1:0] w_next_result;
  logic [FLAG_W-1:0] w_next_band;
  logic [DATA_W-1:0] r_result;
  logic [FLAG_W-1:0] r_band;

  alu_comb u_comb (
    .fun         (fun),
    .Rx          (Rx),
    .Ry          (Ry),
    .next_result (w_next_result),
    .next_band   (w_next_band)
  );

  // Output register: recomputes every edge, cleared at once by reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_result <= '0;
      r_band   <= '0;
    end else begin
      r_result <= w_next_result;
      r_band   <= w_next_band;
    end
  end

  assign Result = r_result;
  assign band   = r_band;

endmodule

// File: tb/tb_alu_8bit.sv
// tb_alu_8bit: directed and randomized checks of alu_8bit against an
// arithmetic reference model.
module tb_alu_8bit;

  logic       clk;
  logic       rst_n;
  logic [2:0] fun;
  logic [7:0] Rx;
  logic [7:0] Ry;
  logic [7:0] Result;
  logic [2:0] band;

  int errors = 0;
  int checks = 0;

  alu_8bit dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .fun    (fun),
    .Rx     (Rx),
    .Ry     (Ry),
    .Result (Result),
    .band   (band)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model from the operation rules, plain integer arithmetic
  function automatic void model(input logic [2:0] f, input logic [7:0] a8,
                                input logic [7:0] b8, output logic [7:0] r,
                                output logic [2:0] fl);
    int a, b, s, c;
    a = int'(a8);
    b = int'(b8);
    c = 0;
    case (f)
      3'd0: begin s = a + b;  c = (s > 255) ? 1 : 0; end
      3'd1: begin s = a - b + 256; c = (a < b) ? 1 : 0; end
      3'd2: s = int'(a8 & b8);
      3'd3: s = int'(a8 | b8);
      3'd4: s = int'(a8 ^ b8);
      3'd5: s = 255 - a;
`ifdef ALU_ROTATE_EN
      3'd6: begin s = a * 2 + a / 128; c = a / 128; end
      3'd7: begin s = a / 2 + (a % 2) * 128; c = a % 2; end
`else
      3'd6: begin s = a * 2; c = a / 128; end
      3'd7: begin s = a / 2; c = a % 2; end
`endif
      default: s = 0;
    endcase
    s  = s % 256;
    r  = 8'(s);
    fl = {(s >= 128) ? 1'b1 : 1'b0, c[0], (s == 0) ? 1'b1 : 1'b0};
  endfunction

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed=%02h expected=%02h", tag, obs, exp);
    end
  endtask

  // Drive on the falling edge, sample 1 time unit after the rising edge
  task automatic step(input logic [2:0] f, input logic [7:0] a, input logic [7:0] b,
                      input string tag);
    logic [7:0] er;
    logic [2:0] eb;
    @(negedge clk);
    fun = f; Rx = a; Ry = b;
    @(posedge clk);
    #1;
    model(f, a, b, er, eb);
    $display("op fun=%03b Rx=%02h Ry=%02h -> Result=%02h band=%03b (exp %02h/%03b)",
             f, a, b, Result, band, er, eb);
    chk({tag, "_res"}, Result, er);
    chk({tag, "_band"}, {5'b0, band}, {5'b0, eb});
  endtask

  // Expected table for the Rx=01, Ry=FF opcode sweep
  logic [7:0] sweep_res [8];
  logic [2:0] sweep_band [8];

  initial begin
    sweep_res  = '{8'h00, 8'h02, 8'h01, 8'hFF, 8'hFE, 8'hFE, 8'h02, 8'h00};
    sweep_band = '{3'b011, 3'b010, 3'b000, 3'b100, 3'b100, 3'b100, 3'b000, 3'b011};
`ifdef ALU_ROTATE_EN
    sweep_res[7]  = 8'h80;
    sweep_band[7] = 3'b110;
`endif

    // Reset held with toggling inputs
    rst_n = 1'b0; fun = 3'd0; Rx = 8'h00; Ry = 8'h00;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      fun = 3'(i); Rx = 8'(8'h3C + i); Ry = 8'hF0;
      @(posedge clk); #1;
      $display("reset cycle %0d: Result=%02h band=%03b", i, Result, band);
      chk("reset_res", Result, 8'h00);
      chk("reset_band", {5'b0, band}, 8'h00);
    end

    // Release reset: outputs stay clear until the next rising edge
    @(negedge clk);
    fun = 3'd0; Rx = 8'h12; Ry = 8'h34;
    rst_n = 1'b1;
    #2;
    chk("post_release_hold", Result, 8'h00);
    @(posedge clk); #1;
    $display("first after reset: Result=%02h band=%03b", Result, band);
    chk("first_result", Result, 8'h46);
    chk("first_band", {5'b0, band}, 8'h00);

    // Opcode sweep, back to back, against the fixed table
    for (int f = 0; f < 8; f++) begin
      @(negedge clk);
      fun = 3'(f); Rx = 8'h01; Ry = 8'hFF;
      @(posedge clk); #1;
      $display("sweep fun=%03b Result=%02h band=%03b (exp %02h/%03b)",
               fun, Result, band, sweep_res[f], sweep_band[f]);
      chk($sformatf("sweep%0d_res", f), Result, sweep_res[f]);
      chk($sformatf("sweep%0d_band", f), {5'b0, band}, {5'b0, sweep_band[f]});
    end

    // Boundary cases
    step(3'd1, 8'h05, 8'h05, "sub_eq");
    chk("sub_eq_zero", {5'b0, band}, 8'h01);
    step(3'd1, 8'h00, 8'h01, "sub_wrap");
    chk("sub_wrap_ff", Result, 8'hFF);
    step(3'd0, 8'h7F, 8'h01, "add_nc");
    chk("add_nc_band", {5'b0, band}, 8'h04);
    step(3'd0, 8'hFF, 8'h01, "add_wrap");
    chk("add_wrap_band", {5'b0, band}, 8'h03);
    step(3'd6, 8'h81, 8'h00, "shl_msb");
    step(3'd7, 8'h81, 8'h00, "shr_lsb");

    // Outputs hold while inputs are unchanged
    @(posedge clk); #1;
    chk("hold_res", Result, (8'h81 >> 1) | (
`ifdef ALU_ROTATE_EN
      8'h80
`else
      8'h00
`endif
      ));

    // Randomized operations
    for (int i = 0; i < 200; i++)
      step(3'($urandom_range(0, 7)), 8'($urandom), 8'($urandom), "rand");

    // Asynchronous reset between edges during an ADD
    step(3'd0, 8'hF0, 8'h0F, "pre_async");
    @(posedge clk); #3;
    rst_n = 1'b0;
    #1;
    $display("async reset mid-cycle: Result=%02h band=%03b", Result, band);
    chk("async_res", Result, 8'h00);
    chk("async_band", {5'b0, band}, 8'h00);
    @(negedge clk);
    rst_n = 1'b1;
    step(3'd4, 8'hAA, 8'h55, "after_async");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Global watchdog
  initial begin
    #200000;
    errors++;
    $display("FAIL timeout: simulation did not finish");
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $fatal(1, "timeout");
  end

endmodule
